// File: rtl/fifo_drain_framer.sv
// Drains 32-bit TDC words from a non-FWFT FIFO and emits framed bytes: header, payload MSB-first, count, XOR checksum.
// One read in flight at a time; tx_data/tx_valid hold while tx_ready is low, so the frame simply stretches.
module fifo_drain_framer #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned BURST_LEN  = 64,
  parameter logic [7:0]  FRAME_HDR  = 8'hA5
) (
  input  logic        Rclk,
  input  logic        Rst_n,
  input  logic        fifo_empty,
  input  logic        fifo_almost_empty,
  input  logic [31:0] fifo_data,
  output logic        fifo_rden,
  input  logic        flush,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_WAIT, PAYLOAD, CNT, CHK} state_t;

  localparam logic [1:0] LAT   = 2'(RD_LATENCY);
  localparam logic [7:0] BURST = 8'(BURST_LEN);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] word_q;
  logic [1:0]  byte_idx;
  logic [1:0]  lat_cnt;
  logic [7:0]  count;
  logic [7:0]  count_inc;
  logic [7:0]  checksum;

  assign count_inc = count + 8'd1;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    fifo_rden = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE: begin
        if (!fifo_almost_empty || (flush && !fifo_empty)) state_nxt = HDR;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = FRAME_HDR;
        if (tx_ready) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        if (fifo_empty) begin
          state_nxt = CNT;
        end else begin
          fifo_rden = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LAT) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        // word_q shifts left on every transfer, so the next byte is always on top
        tx_valid = 1'b1;
        tx_data  = word_q[31:24];
        if (tx_ready && byte_idx == 2'd3) state_nxt = (count_inc == BURST) ? CNT : RD_REQ;
      end
      CNT: begin
        tx_valid = 1'b1;
        tx_data  = count;
        if (tx_ready) state_nxt = CHK;
      end
      CHK: begin
        tx_valid = 1'b1;
        tx_data  = checksum;
        if (tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Rclk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      word_q      <= 32'h0;
      byte_idx    <= 2'd0;
      lat_cnt     <= 2'd0;
      count       <= 8'h00;
      checksum    <= 8'h00;
      frames_sent <= 16'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (state_nxt == HDR) begin
            count    <= 8'h00;
            checksum <= 8'h00;
          end
        end
        RD_REQ: begin
          // the rden cycle itself counts as latency cycle zero
          if (!fifo_empty) lat_cnt <= 2'd1;
        end
        RD_WAIT: begin
          if (lat_cnt == LAT) begin
            word_q   <= fifo_data;
            byte_idx <= 2'd0;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        PAYLOAD: begin
          if (tx_ready) begin
            word_q   <= {word_q[23:0], 8'h00};
            byte_idx <= byte_idx + 2'd1;
            checksum <= checksum ^ word_q[31:24];
            if (byte_idx == 2'd3) count <= count_inc;
          end
        end
        CNT: begin
          if (tx_ready) checksum <= checksum ^ count;
        end
        CHK: begin
          if (tx_ready) frames_sent <= frames_sent + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_framer.sv
// Bench for fifo_drain_framer: FIFO model with 2-cycle registered read, byte monitor and a frame-level reference model.
module tb_fifo_drain_framer;
  localparam int AE_OFF = 64;
  localparam int BURST  = 64;

  logic        Rclk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_almost_empty = 1'b1;
  logic [31:0] fifo_data = 32'h0;
  logic        fifo_rden;
  logic        flush = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] frames_sent;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;

  logic [31:0] fq[$];
  logic [31:0] mq[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic        st1_vld = 1'b0;
  logic [31:0] st1 = 32'h0;

  logic rnd_ready = 1'b0;
  logic fix_ready = 1'b1;
  logic rnd_bit = 1'b1;

  int cyc = 0;
  int rden_cnt = 0;
  int rden_empty = 0;
  int min_gap = 1000000;
  int last_rden = -1;
  int hold_viol = 0;
  int stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 Rclk = ~Rclk;
  assign tx_ready = rnd_ready ? rnd_bit : fix_ready;

  fifo_drain_framer #(.RD_LATENCY(2), .BURST_LEN(BURST), .FRAME_HDR(8'hA5)) dut (
    .Rclk(Rclk), .Rst_n(Rst_n), .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_data(fifo_data), .fifo_rden(fifo_rden), .flush(flush), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .frames_sent(frames_sent)
  );

  // DO carries the popped word only in the cycle exactly 2 after rden; junk otherwise
  always @(posedge Rclk) begin
    fifo_data <= st1_vld ? st1 : $urandom;
    st1_vld = 1'b0;
    if (fifo_rden && fq.size() != 0) begin
      st1 = fq.pop_front();
      st1_vld = 1'b1;
    end
    fifo_empty        <= (fq.size() == 0);
    fifo_almost_empty <= (fq.size() < AE_OFF);
    rnd_bit           <= 1'($urandom_range(0, 1));
  end

  always @(negedge Rclk) begin
    cyc++;
    if (!Rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) hold_viol++;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (tx_valid && !tx_ready) stall_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (fifo_rden) begin
        rden_cnt++;
        if (fifo_empty) rden_empty++;
        if (last_rden >= 0 && (cyc - last_rden) < min_gap) min_gap = cyc - last_rden;
        last_rden = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Rclk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    mq.push_back(w);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_sent !== 16'(target) && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    exp_q.delete();
    rden_cnt = 0;
    rden_empty = 0;
    min_gap = 1000000;
    last_rden = -1;
    hold_viol = 0;
    stall_cnt = 0;
  endtask

  // Reference frame: A5, n words big-endian, n as a byte, XOR of payload and count bytes
  task automatic model_frame(input int n);
    logic [7:0]  chk;
    logic [7:0]  b;
    logic [31:0] w;
    chk = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      w = mq.pop_front();
      for (int k = 3; k >= 0; k--) begin
        b = w[8*k +: 8];
        exp_q.push_back(b);
        chk ^= b;
      end
    end
    b = 8'(n);
    exp_q.push_back(b);
    chk ^= b;
    exp_q.push_back(chk);
  endtask

  function automatic int first_diff();
    int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
    if (rx_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    return (i >= 0 && i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'hxx;
  endfunction

  task automatic test_reset();
    #1 Rst_n = 1'b0;
    step(3);
    checks++; if (fifo_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", fifo_rden); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frames_sent !== 16'h0) begin failures++; $display("FAIL reset_frames got=%0d exp=0", frames_sent); end
    Rst_n = 1'b1;
    step(4);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_empty_busy got=%b exp=0", busy); end
  endtask

  task automatic test_bursts();
    int d;
    int nfr = 0;
    clear_mon();
    for (int i = 1; i <= 200; i++) push_word(32'(i));
    while (mq.size() >= AE_OFF) begin
      model_frame((mq.size() < BURST) ? mq.size() : BURST);
      nfr++;
    end
    exp_frames += nfr;
    wait_frames(exp_frames, 3000);
    step(300);
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL bursts_stream idx=%0d got=%h exp=%h got_len=%0d exp_len=%0d", d, rx_at(d), exp_at(d), rx_q.size(), exp_q.size()); end
    checks++; if (rx_at(0) !== 8'hA5 || rx_at(257) !== 8'h40) begin failures++; $display("FAIL bursts_frame1 hdr=%h cnt=%h exp=a5/40", rx_at(0), rx_at(257)); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin failures++; $display("FAIL bursts_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bursts_busy got=%b exp=0", busy); end
    checks++; if (rden_cnt != 192 || fq.size() != 8) begin failures++; $display("FAIL bursts_reads rden=%0d left=%0d exp=192/8", rden_cnt, fq.size()); end
    fq.delete();
    mq.delete();
    step(3);
  endtask

  task automatic test_flush();
    int d;
    clear_mon();
    flush = 1'b1;
    push_word(32'h11223344);
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
    model_frame(3);
    exp_frames++;
    wait_frames(exp_frames, 500);
    step(20);
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL flush_stream idx=%0d got=%h exp=%h got_len=%0d exp_len=%0d", d, rx_at(d), exp_at(d), rx_q.size(), exp_q.size()); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin failures++; $display("FAIL flush_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    checks++; if (rden_cnt != 3 || rden_empty != 0) begin failures++; $display("FAIL flush_rden pulses=%0d while_empty=%0d exp=3/0", rden_cnt, rden_empty); end
    flush = 1'b0;
    step(2);
  endtask

  task automatic test_backpressure();
    int d;
    clear_mon();
    rnd_ready = 1'b1;
    for (int i = 0; i < 64; i++) push_word($urandom);
    model_frame(64);
    exp_frames++;
    wait_frames(exp_frames, 4000);
    step(20);
    rnd_ready = 1'b0;
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL bp_stream idx=%0d got=%h exp=%h got_len=%0d exp_len=%0d", d, rx_at(d), exp_at(d), rx_q.size(), exp_q.size()); end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL bp_hold violations=%0d exp=0", hold_viol); end
    checks++; if (stall_cnt == 0) begin failures++; $display("FAIL bp_stalls got=0 exp>0"); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin failures++; $display("FAIL bp_frames got=%0d exp=%0d", frames_sent, exp_frames); end
  endtask

  task automatic test_latency();
    int d;
    clear_mon();
    for (int i = 0; i < 64; i++) push_word($urandom);
    model_frame(64);
    exp_frames++;
    wait_frames(exp_frames, 2000);
    step(10);
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL lat_stream idx=%0d got=%h exp=%h got_len=%0d exp_len=%0d", d, rx_at(d), exp_at(d), rx_q.size(), exp_q.size()); end
    checks++; if (min_gap < 7) begin failures++; $display("FAIL lat_gap got=%0d exp>=7", min_gap); end
    checks++; if (rden_cnt != 64 || rden_empty != 0) begin failures++; $display("FAIL lat_rden pulses=%0d while_empty=%0d exp=64/0", rden_cnt, rden_empty); end
  endtask

  task automatic test_reset_mid();
    int d;
    int n = 0;
    clear_mon();
    for (int i = 0; i < 128; i++) push_word($urandom);
    while (rx_q.size() < 8 && n < 500) begin
      step(1);
      n++;
    end
    checks++; if (rx_q.size() < 8 || tx_valid !== 1'b1) begin failures++; $display("FAIL rstmid_payload bytes=%0d tx_valid=%b exp>=8/1", rx_q.size(), tx_valid); end
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx valid=%b data=%h exp=0/00", tx_valid, tx_data); end
    checks++; if (busy !== 1'b0 || fifo_rden !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl busy=%b rden=%b exp=0/0", busy, fifo_rden); end
    checks++; if (frames_sent !== 16'h0) begin failures++; $display("FAIL rstmid_frames got=%0d exp=0", frames_sent); end
    step(3);
    fq.delete();
    mq.delete();
    clear_mon();
    for (int i = 0; i < 128; i++) push_word($urandom);
    model_frame(64);
    model_frame(64);
    exp_frames = 2;
    step(2);
    Rst_n = 1'b1;
    wait_frames(exp_frames, 3000);
    step(20);
    checks++; if (rx_at(0) !== 8'hA5) begin failures++; $display("FAIL rstmid_hdr got=%h exp=a5", rx_at(0)); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL rstmid_stream idx=%0d got=%h exp=%h got_len=%0d exp_len=%0d", d, rx_at(d), exp_at(d), rx_q.size(), exp_q.size()); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin failures++; $display("FAIL rstmid_after got=%0d exp=%0d", frames_sent, exp_frames); end
  endtask

  task automatic test_zero_word();
    int d;
    int n = 0;
    clear_mon();
    fix_ready = 1'b0;
    flush = 1'b1;
    fq.push_back(32'hDEADBEEF);
    while (busy !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_start busy=%b exp=1", busy); end
    fq.delete();
    step(3);
    fix_ready = 1'b1;
    model_frame(0);
    exp_frames++;
    wait_frames(exp_frames, 100);
    step(10);
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL zero_stream idx=%0d got=%h exp=%h got_len=%0d exp_len=%0d", d, rx_at(d), exp_at(d), rx_q.size(), exp_q.size()); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin failures++; $display("FAIL zero_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    checks++; if (rden_cnt != 0) begin failures++; $display("FAIL zero_rden pulses=%0d exp=0", rden_cnt); end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bursts();
    test_flush();
    test_backpressure();
    test_latency();
    test_reset_mid();
    test_zero_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
